// File: rtl/ysyx_22050058_mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and
// multiply-control FSM states.
package ysyx_22050058_mdu_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        MULCTRL_ST_IDLE  = 3'd0,
        MULCTRL_ST_ISSUE = 3'd1,
        MULCTRL_ST_WAIT  = 3'd2,
        MULCTRL_ST_FIX   = 3'd3,
        MULCTRL_ST_RESP  = 3'd4,
        MULCTRL_ST_DRAIN = 3'd5
    } mulctrl_state_e;

endpackage

// File: rtl/ysyx_22050058_mul_ctrl_if.sv
// Request/response handshake between EXU issue logic (master) and the
// multiply control block (slave).
interface ysyx_22050058_mul_ctrl_if;
    import ysyx_22050058_mdu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    mul_op_e           req_op;
    logic              req_word;
    logic [DATA_W-1:0] req_src1;
    logic [DATA_W-1:0] req_src2;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_op, req_word, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_word, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/ysyx_22050058_mul_fix.sv
// Turns the core's signed x signed 128-bit product into the RV64M result:
// unsigned-operand correction of the high half and MULW sign-extension.
module ysyx_22050058_mul_fix
    import ysyx_22050058_mdu_pkg::*;
(
    input  mul_op_e           op,
    input  logic              word,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] res
);

    function automatic logic [DATA_W-1:0] sext_word(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    logic signed [DATA_W-1:0] hi_s;
    logic signed [DATA_W-1:0] corr_su;
    logic signed [DATA_W-1:0] corr_u;

    // Reinterpreting a negative signed operand as unsigned adds 2^64 * other
    // operand to the product, i.e. the other operand to the high half.
    always_comb begin
        hi_s    = hi;
        corr_su = src2[DATA_W-1] ? src1 : '0;
        corr_u  = src1[DATA_W-1] ? src2 : '0;
        res     = lo;
        if (word) begin
            res = sext_word(lo[31:0]);
        end else begin
            case (op)
                MUL_OP_MUL:    res = lo;
                MUL_OP_MULH:   res = hi_s;
                MUL_OP_MULHSU: res = hi_s + corr_su;
                MUL_OP_MULHU:  res = hi_s + corr_su + corr_u;
                default:       res = lo;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22050058_mul_ctrl.sv
// RV64M multiply control: issues one request to the Booth/Wallace core,
// corrects the product and returns it over a valid/ready response with flush.
module ysyx_22050058_mul_ctrl
    import ysyx_22050058_mdu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    ysyx_22050058_mul_ctrl_if.slave   bus,
    output logic                      busy_o,
    output logic                      core_valid_o,
    output logic                      core_ready_o,
    output logic [DATA_W-1:0]         core_a_o,
    output logic [DATA_W-1:0]         core_b_o,
    input  logic                      core_valid_i,
    input  logic [DATA_W-1:0]         core_hi_i,
    input  logic [DATA_W-1:0]         core_lo_i
);

    mulctrl_state_e    state_q, state_d;
    mul_op_e           op_p0;
    logic              word_p0;
    logic [DATA_W-1:0] hi_p1, lo_p1;
    logic [DATA_W-1:0] fix_res;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_valid_q;
    logic              accept;
    logic              capture;
    logic              load_resp;

    assign bus.req_ready  = (state_q == MULCTRL_ST_IDLE) && !flush;
    assign accept         = bus.req_valid && bus.req_ready;
    assign core_valid_o   = (state_q == MULCTRL_ST_ISSUE);
    assign core_ready_o   = core_valid_i &&
                            (state_q == MULCTRL_ST_WAIT || state_q == MULCTRL_ST_DRAIN);
    assign capture        = (state_q == MULCTRL_ST_WAIT) && core_valid_i && !flush;
    assign load_resp      = (state_q == MULCTRL_ST_FIX) && !flush;
    assign busy_o         = (state_q != MULCTRL_ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MULCTRL_ST_IDLE:  if (accept) state_d = MULCTRL_ST_ISSUE;
            MULCTRL_ST_ISSUE: state_d = flush ? MULCTRL_ST_DRAIN : MULCTRL_ST_WAIT;
            MULCTRL_ST_WAIT: begin
                if (flush)             state_d = core_valid_i ? MULCTRL_ST_IDLE : MULCTRL_ST_DRAIN;
                else if (core_valid_i) state_d = MULCTRL_ST_FIX;
            end
            MULCTRL_ST_FIX:   state_d = flush ? MULCTRL_ST_IDLE : MULCTRL_ST_RESP;
            MULCTRL_ST_RESP:  if (flush || bus.resp_ready) state_d = MULCTRL_ST_IDLE;
            MULCTRL_ST_DRAIN: if (core_valid_i) state_d = MULCTRL_ST_IDLE;
            default:          state_d = MULCTRL_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MULCTRL_ST_IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= (state_d == MULCTRL_ST_RESP);
        end
    end

    // Stage p0: operands latched on accept; they feed the core directly and
    // stay put until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_a_o <= '0;
            core_b_o <= '0;
        end else if (accept) begin
            core_a_o <= bus.req_src1;
            core_b_o <= bus.req_src2;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0   <= bus.req_op;
            word_p0 <= bus.req_word;
        end
    end

    // Stage p1: raw product captured from the core.
    always_ff @(posedge clk) begin
        if (capture) begin
            hi_p1 <= core_hi_i;
            lo_p1 <= core_lo_i;
        end
    end

    ysyx_22050058_mul_fix u_fix (
        .op   (op_p0),
        .word (word_p0),
        .src1 (core_a_o),
        .src2 (core_b_o),
        .hi   (hi_p1),
        .lo   (lo_p1),
        .res  (fix_res)
    );

    // Stage p2: corrected writeback value, held through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_q <= '0;
        end else if (load_resp) begin
            resp_data_q <= fix_res;
        end
    end

endmodule

// File: tb/tb_ysyx_22050058_mul_ctrl.sv
// Directed bench for ysyx_22050058_mul_ctrl with a 4-cycle behavioural
// signed x signed multiplier core.
module tb_ysyx_22050058_mul_ctrl;
    import ysyx_22050058_mdu_pkg::*;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        busy_o, core_valid_o, core_ready_o;
    logic [63:0] core_a_o, core_b_o;
    logic        core_valid_i;
    logic [63:0] core_hi_i, core_lo_i;

    ysyx_22050058_mul_ctrl_if bus ();

    ysyx_22050058_mul_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .busy_o       (busy_o),
        .core_valid_o (core_valid_o),
        .core_ready_o (core_ready_o),
        .core_a_o     (core_a_o),
        .core_b_o     (core_b_o),
        .core_valid_i (core_valid_i),
        .core_hi_i    (core_hi_i),
        .core_lo_i    (core_lo_i)
    );

    always #5 clk = ~clk;

    // Reference core: signed x signed product, valid L cycles after the
    // issue pulse, held until acknowledged by core_ready_o.
    function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb;
        ea = {{64{a[63]}}, a};
        eb = {{64{b[63]}}, b};
        return ea * eb;
    endfunction

    logic         pend;
    int           cnt;
    logic [127:0] prod;

    always @(posedge clk) begin
        if (rst) begin
            core_valid_i <= 1'b0;
            core_hi_i    <= '0;
            core_lo_i    <= '0;
            pend         <= 1'b0;
            cnt          <= 0;
            prod         <= '0;
        end else begin
            if (core_ready_o) core_valid_i <= 1'b0;
            if (core_valid_o) begin
                pend <= 1'b1;
                cnt  <= L - 1;
                prod <= smul(core_a_o, core_b_o);
            end else if (pend) begin
                if (cnt == 1) begin
                    core_valid_i <= 1'b1;
                    core_hi_i    <= prod[127:64];
                    core_lo_i    <= prod[63:0];
                    pend         <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[11];

    // Drives one request at a negedge; returns just after the accepting edge.
    task automatic start_req(input logic [1:0] op, input logic word,
                             input logic [63:0] a, input logic [63:0] b);
        int k;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = mul_op_e'(op);
        bus.req_word  = word;
        bus.req_src1  = a;
        bus.req_src2  = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Counts negedges after the accept until resp_valid; 21 means timeout.
    task automatic wait_resp(output int k);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.resp_valid) break;
        end
    endtask

    task automatic do_req(input vec_t v);
        int k;
        start_req(v.op, v.word, v.a, v.b);
        wait_resp(k);
        chk({"latency_", v.name}, 64'(k), 64'd7);
        chk({"data_", v.name}, bus.resp_data, v.exp);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk({"post_valid_", v.name}, {63'd0, bus.resp_valid}, 64'd0);
        chk({"post_ready_", v.name}, {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  saw_resp, saw_ack;
        vec_t v;

        vecs[0]  = '{2'b00, 1'b0, 64'd3, 64'd5, 64'hF, "mul_3x5"};
        vecs[1]  = '{2'b11, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, "mulhu_max"};
        vecs[2]  = '{2'b10, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_max"};
        vecs[3]  = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     64'h4000_0000_0000_0000, "mulh_min_sq"};
        vecs[4]  = '{2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw_ovf"};
        vecs[5]  = '{2'b00, 1'b1, 64'h1_0000_0003, 64'd2, 64'h6, "mulw_trunc"};
        vecs[6]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mul_neg"};
        vecs[7]  = '{2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'h1, "mulhu_msb"};
        vecs[8]  = '{2'b01, 1'b0, '1, '1, 64'h0, "mulh_m1"};
        vecs[9]  = '{2'b11, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h1, "mulw_opignored"};
        vecs[10] = '{2'b10, 1'b0, 64'd2, '1, 64'h1, "mulhsu_pos"};

        bus.req_valid  = 1'b0;
        bus.req_op     = MUL_OP_MUL;
        bus.req_word   = 1'b0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.resp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_resp_data", bus.resp_data, 64'd0);
        chk("rst_core_valid", {63'd0, core_valid_o}, 64'd0);
        chk("rst_core_a", core_a_o, 64'd0);
        chk("rst_core_b", core_b_o, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            v = vecs[i];
            do_req(v);
        end

        // Flush while waiting on the core
        start_req(2'b00, 1'b0, 64'd9, 64'd9);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("flush_wait_busy_before", {63'd0, busy_o}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        saw_resp = 1'b0;
        saw_ack  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.resp_valid) saw_resp = 1'b1;
            if (core_valid_i && core_ready_o) saw_ack = 1'b1;
        end
        chk("flush_wait_no_resp", {63'd0, saw_resp}, 64'd0);
        chk("flush_wait_core_ack", {63'd0, saw_ack}, 64'd1);
        chk("flush_wait_idle", {63'd0, busy_o}, 64'd0);
        chk("flush_wait_core_clear", {63'd0, core_valid_i}, 64'd0);
        v = '{2'b00, 1'b0, 64'd7, 64'd6, 64'd42, "mul_after_flush"};
        do_req(v);

        // Flush while the result is being offered
        start_req(2'b00, 1'b0, 64'd2, 64'd3);
        wait_resp(k);
        chk("flush_resp_latency", 64'(k), 64'd7);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid_drop", {63'd0, bus.resp_valid}, 64'd0);
        chk("flush_resp_idle", {63'd0, busy_o}, 64'd0);

        // Flush in IDLE blocks acceptance
        bus.req_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_idle_req_ready", {63'd0, bus.req_ready}, 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_not_accepted", {63'd0, busy_o}, 64'd0);

        // Backpressure: result held for 10 cycles
        start_req(2'b00, 1'b0, 64'h1234, 64'h10);
        wait_resp(k);
        chk("bp_latency", 64'(k), 64'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", {63'd0, bus.resp_valid}, 64'd1);
            chk("bp_data_hold", bus.resp_data, 64'h12340);
            chk("bp_req_ready_low", {63'd0, bus.req_ready}, 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("bp_release_valid", {63'd0, bus.resp_valid}, 64'd0);

        // Reset mid-operation
        start_req(2'b00, 1'b0, 64'd11, 64'd11);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {63'd0, busy_o}, 64'd0);
        chk("midrst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("midrst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        v = '{2'b00, 1'b0, 64'd12, 64'd12, 64'd144, "mul_after_rst"};
        do_req(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
